// File: rtl/sensor_ae_pkg.sv
// Shared widths, FSM state type and the frame-mean helper for the auto-exposure controller.
package sensor_ae_pkg;

  localparam int unsigned EXP_W  = 32;
  localparam int unsigned MEAN_W = 12;
  localparam int unsigned SUM_W  = 40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_STATS,
    ST_CALC,
    ST_ADJUST,
    ST_ISSUE
  } ae_state_e;

  // Mean of the frame sum, saturated to the largest MEAN_W-bit value.
  function automatic logic [MEAN_W-1:0] calc_mean(input logic [SUM_W-1:0] sum,
                                                  input logic [4:0]       shift);
    logic [SUM_W-1:0] q;
    q = sum >> shift;
    if (q[SUM_W-1:MEAN_W] != '0) return '1;
    return q[MEAN_W-1:0];
  endfunction

endpackage

// File: rtl/sensor_ae_step.sv
// Combinational dead-band test, step size and clamped exposure update.
module sensor_ae_step
  import sensor_ae_pkg::*;
(
  input  logic [EXP_W-1:0]  exp_cur,
  input  logic [MEAN_W-1:0] mean,
  input  logic [MEAN_W-1:0] target_mean,
  input  logic [MEAN_W-1:0] tolerance,
  input  logic [3:0]        step_shift,
  input  logic [EXP_W-1:0]  exp_min,
  input  logic [EXP_W-1:0]  exp_max,
  output logic              locked,
  output logic [EXP_W-1:0]  exp_new,
  output logic              update
);

  logic [MEAN_W-1:0] err;
  logic [EXP_W-1:0]  step_raw;
  logic [EXP_W-1:0]  step;
  logic [EXP_W:0]    up_sum;
  logic [EXP_W-1:0]  up_val;
  logic [EXP_W-1:0]  dn_diff;
  logic [EXP_W-1:0]  dn_val;

  always_comb begin
    err      = (mean < target_mean) ? (target_mean - mean) : (mean - target_mean);
    locked   = (err <= tolerance);

    step_raw = exp_cur >> step_shift;
    step     = (step_raw == '0) ? EXP_W'(1) : step_raw;

    // 33-bit sum so a large exposure cannot wrap before the upper clamp.
    up_sum   = {1'b0, exp_cur} + {1'b0, step};
    up_val   = (up_sum > {1'b0, exp_max}) ? exp_max : up_sum[EXP_W-1:0];

    dn_diff  = (exp_cur >= step) ? (exp_cur - step) : '0;
    dn_val   = (dn_diff < exp_min) ? exp_min : dn_diff;

    exp_new  = (mean < target_mean) ? up_val : dn_val;
    update   = !locked && (exp_new != exp_cur);
  end

endmodule

// File: rtl/sensor_ae_ctrl.sv
// Auto-exposure controller: per-frame mean, dead-band check and valid/ready exposure update.
module sensor_ae_ctrl
  import sensor_ae_pkg::*;
#(
  parameter logic [31:0] EXP_INIT = 32'd1000,
  parameter string       DEBUG    = "FALSE"
) (
  input  logic              px_clk,
  input  logic              px_reset_n,
  input  logic              vs_in,
  input  logic [31:0]       gray_sum_L_in,
  input  logic [31:0]       gray_sum_H_in,
  input  logic [EXP_W-1:0]  exp_time_in,
  input  logic              ae_en,
  input  logic [MEAN_W-1:0] target_mean,
  input  logic [MEAN_W-1:0] tolerance,
  input  logic [4:0]        pix_log2,
  input  logic [3:0]        step_shift,
  input  logic [EXP_W-1:0]  exp_min,
  input  logic [EXP_W-1:0]  exp_max,
  input  logic [3:0]        skip_frames,
  output logic [EXP_W-1:0]  exp_set,
  output logic              exp_set_valid,
  input  logic              exp_set_ready,
  output logic [MEAN_W-1:0] ae_mean,
  output logic              ae_locked
);

  ae_state_e         state, state_nxt;
  logic              vs_q;
  logic              frame_end;
  logic [SUM_W-1:0]  sum_q;
  logic [3:0]        skip_cnt;
  logic [EXP_W-1:0]  exp_cur;
  logic              step_locked;
  logic [EXP_W-1:0]  step_exp_new;
  logic              step_update;
  logic              unused_sum_hi;

  assign frame_end     = vs_q && !vs_in;
  assign unused_sum_hi = ^gray_sum_H_in[31:8];

  sensor_ae_step u_step (
    .exp_cur     (exp_cur),
    .mean        (ae_mean),
    .target_mean (target_mean),
    .tolerance   (tolerance),
    .step_shift  (step_shift),
    .exp_min     (exp_min),
    .exp_max     (exp_max),
    .locked      (step_locked),
    .exp_new     (step_exp_new),
    .update      (step_update)
  );

  always_ff @(posedge px_clk or negedge px_reset_n) begin
    if (!px_reset_n) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:       if (frame_end && skip_cnt == '0) state_nxt = ST_WAIT_STATS;
      ST_WAIT_STATS: state_nxt = ST_CALC;
      ST_CALC:       state_nxt = ST_ADJUST;
      ST_ADJUST:     state_nxt = (ae_en && step_update) ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:      if (exp_set_ready) state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    exp_set_valid = (state == ST_ISSUE);
  end

  // Frame ends outside IDLE fall through every branch here, so they are dropped, not queued.
  always_ff @(posedge px_clk or negedge px_reset_n) begin
    if (!px_reset_n) begin
      vs_q      <= 1'b0;
      sum_q     <= '0;
      ae_mean   <= '0;
      ae_locked <= 1'b0;
      exp_cur   <= EXP_INIT;
      exp_set   <= EXP_INIT;
      skip_cnt  <= '0;
    end else begin
      vs_q <= vs_in;
      unique case (state)
        ST_IDLE: begin
          if (frame_end) begin
            if (skip_cnt != '0) skip_cnt <= skip_cnt - 4'd1;
            if (!ae_en)         exp_cur  <= exp_time_in;
          end
        end
        ST_WAIT_STATS: sum_q   <= {gray_sum_H_in[7:0], gray_sum_L_in};
        ST_CALC:       ae_mean <= calc_mean(sum_q, pix_log2);
        ST_ADJUST: begin
          if (ae_en) begin
            ae_locked <= step_locked;
            if (step_update) begin
              exp_cur  <= step_exp_new;
              exp_set  <= step_exp_new;
              skip_cnt <= skip_frames;
            end
          end
        end
        default: ;
      endcase
    end
  end

  if (DEBUG == "TRUE") begin : g_debug
    always_ff @(posedge px_clk) begin
      if (px_reset_n && exp_set_valid)
        assert (exp_set == exp_cur);
    end
  end

endmodule

// File: tb/tb_sensor_ae_ctrl.sv
// Directed and randomized frames for sensor_ae_ctrl, checked against an arithmetic model.
module tb_sensor_ae_ctrl;

  logic        px_clk = 1'b0;
  logic        px_reset_n;
  logic        vs_in;
  logic [31:0] gray_sum_L_in, gray_sum_H_in;
  logic [31:0] exp_time_in;
  logic        ae_en;
  logic [11:0] target_mean, tolerance;
  logic [4:0]  pix_log2;
  logic [3:0]  step_shift;
  logic [31:0] exp_min, exp_max;
  logic [3:0]  skip_frames;
  logic [31:0] exp_set;
  logic        exp_set_valid;
  logic        exp_set_ready;
  logic [11:0] ae_mean;
  logic        ae_locked;

  sensor_ae_ctrl #(.EXP_INIT(32'd1000), .DEBUG("TRUE")) dut (
    .px_clk        (px_clk),
    .px_reset_n    (px_reset_n),
    .vs_in         (vs_in),
    .gray_sum_L_in (gray_sum_L_in),
    .gray_sum_H_in (gray_sum_H_in),
    .exp_time_in   (exp_time_in),
    .ae_en         (ae_en),
    .target_mean   (target_mean),
    .tolerance     (tolerance),
    .pix_log2      (pix_log2),
    .step_shift    (step_shift),
    .exp_min       (exp_min),
    .exp_max       (exp_max),
    .skip_frames   (skip_frames),
    .exp_set       (exp_set),
    .exp_set_valid (exp_set_valid),
    .exp_set_ready (exp_set_ready),
    .ae_mean       (ae_mean),
    .ae_locked     (ae_locked)
  );

  always #5 px_clk = ~px_clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Behavioural model state
  longint m_cur, m_set, m_mean;
  int     m_skip;
  bit     m_locked;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_cur = 1000; m_set = 1000; m_mean = 0; m_skip = 0; m_locked = 0;
  endtask

  task automatic model_frame(input longint sum, output bit issue);
    longint err, step, nv;
    issue = 0;
    if (!ae_en) m_cur = exp_time_in;
    if (m_skip > 0) begin
      m_skip--;
      return;
    end
    m_mean = sum / (longint'(1) << pix_log2);
    if (m_mean > 4095) m_mean = 4095;
    if (ae_en) begin
      err = m_mean - longint'(target_mean);
      if (err < 0) err = -err;
      if (err <= longint'(tolerance)) m_locked = 1;
      else begin
        m_locked = 0;
        step = m_cur / (longint'(1) << step_shift);
        if (step == 0) step = 1;
        if (m_mean < longint'(target_mean)) begin
          nv = m_cur + step;
          if (nv > longint'(exp_max)) nv = exp_max;
        end else begin
          nv = m_cur - step;
          if (nv < 0) nv = 0;
          if (nv < longint'(exp_min)) nv = exp_min;
        end
        if (nv != m_cur) begin
          issue = 1; m_cur = nv; m_set = nv; m_skip = skip_frames;
        end
      end
    end
  endtask

  // One frame: vs_in falls at a negedge; the following posedge ends cycle N.
  task automatic do_frame(input string tag, input logic [39:0] sum);
    logic [31:0] junk;
    bit issue;
    @(negedge px_clk);
    junk = $urandom();
    gray_sum_L_in = sum[31:0];
    gray_sum_H_in = {junk[31:8], sum[39:32]};
    vs_in = 1'b1;
    @(negedge px_clk);
    @(negedge px_clk);
    vs_in = 1'b0;
    model_frame(longint'(sum), issue);
    repeat (3) @(posedge px_clk);
    #1 check({tag, "_pre"}, 40'(exp_set_valid), 40'd0);
    @(posedge px_clk);
    #1 check({tag, "_valid"}, 40'(exp_set_valid), 40'(issue));
    check({tag, "_set"}, 40'(exp_set), 40'(m_set));
    check({tag, "_mean"}, 40'(ae_mean), 40'(m_mean));
    check({tag, "_lock"}, 40'(ae_locked), 40'(m_locked));
    if (issue && exp_set_ready) begin
      @(posedge px_clk);
      #1 check({tag, "_drop"}, 40'(exp_set_valid), 40'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] s;
    logic [31:0] hold, r;
    int unsigned p;
    px_reset_n = 1'b0; vs_in = 1'b0;
    gray_sum_L_in = '0; gray_sum_H_in = '0; exp_time_in = '0;
    ae_en = 1'b1; target_mean = 12'd2048; tolerance = 12'd64;
    pix_log2 = 5'd10; step_shift = 4'd3; exp_min = 32'd16; exp_max = 32'd4096;
    skip_frames = 4'd0; exp_set_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge px_clk);
    #1;
    check("rst_set", 40'(exp_set), 40'd1000);
    check("rst_valid", 40'(exp_set_valid), 40'd0);
    check("rst_mean", 40'(ae_mean), 40'd0);
    check("rst_lock", 40'(ae_locked), 40'd0);
    @(negedge px_clk) px_reset_n = 1'b1;

    do_frame("up1000", 40'd1_024_000);
    check("up1000_const", 40'(m_set), 40'd1125);
    do_frame("down3000", 40'd3_072_000);
    do_frame("lock2080", 40'd2_129_920);
    do_frame("sat4095", 40'h01_0000_0000);

    ae_en = 1'b0; exp_time_in = 32'd4000;
    do_frame("man4000", 40'd1_024_000);
    ae_en = 1'b1;
    do_frame("clamp", 40'd1_024_000);
    check("clamp_const", 40'(exp_set), 40'd4096);

    ae_en = 1'b0; exp_time_in = 32'd777;
    do_frame("man777", 40'd3_072_000);
    ae_en = 1'b1;
    do_frame("bump", 40'd1_024_000);
    check("bump_const", 40'(exp_set), 40'd874);

    // Ready held low; a frame end and ae_en drop inside the window must not disturb it.
    exp_set_ready = 1'b0;
    do_frame("hold", 40'd1_024_000);
    hold = exp_set;
    for (int i = 0; i < 5; i++) begin
      @(negedge px_clk);
      if (i == 1) vs_in = 1'b1;
      if (i == 3) begin vs_in = 1'b0; ae_en = 1'b0; end
      check("hold_valid", 40'(exp_set_valid), 40'd1);
      check("hold_set", 40'(exp_set), 40'(hold));
    end
    @(negedge px_clk);
    exp_set_ready = 1'b1; ae_en = 1'b1;
    @(posedge px_clk);
    #1 check("hold_drop", 40'(exp_set_valid), 40'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge px_clk);
      #1 check("hold_no2nd", 40'(exp_set_valid), 40'd0);
    end

    skip_frames = 4'd2;
    do_frame("skip_iss", 40'd1_024_000);
    skip_frames = 4'd0;
    do_frame("skip1", 40'd3_072_000);
    do_frame("skip2", 40'd3_072_000);
    do_frame("skip3", 40'd3_072_000);

    // Reset while a transaction is pending
    exp_set_ready = 1'b0;
    do_frame("rstiss", 40'd1_024_000);
    #2 px_reset_n = 1'b0;
    #1;
    model_reset();
    check("rstiss_valid", 40'(exp_set_valid), 40'd0);
    check("rstiss_set", 40'(exp_set), 40'd1000);
    check("rstiss_mean", 40'(ae_mean), 40'd0);
    @(negedge px_clk);
    px_reset_n = 1'b1; exp_set_ready = 1'b1;
    do_frame("postrst", 40'd3_072_000);

    for (int k = 0; k < 40; k++) begin
      p = $urandom_range(6, 14);
      pix_log2    = 5'(p);
      target_mean = 12'($urandom_range(0, 4095));
      tolerance   = 12'($urandom_range(0, 300));
      step_shift  = 4'($urandom_range(0, 15));
      exp_min     = $urandom_range(0, 200);
      exp_max     = exp_min + $urandom_range(0, 6000);
      exp_time_in = $urandom_range(1, 5000);
      skip_frames = 4'($urandom_range(0, 2));
      ae_en       = ($urandom_range(0, 4) != 0);
      r = $urandom();
      s = (40'($urandom_range(0, 4300)) << p) + 40'(r & ((32'd1 << p) - 1));
      if ($urandom_range(0, 9) == 0) s[39:32] = 8'($urandom_range(1, 255));
      do_frame("rand", s);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sensor_ae_ctrl.md
SENSOR_AE_CTRL -- requirements
Module: sensor_ae_ctrl

Interface
REQ-001 Parameter EXP_INIT, 32'd1000: exposure value loaded into exp_cur at reset.
REQ-002 Parameter DEBUG, "FALSE": debug-only instrumentation switch; no functional effect.
REQ-003 px_clk  in  1  pixel clock; all logic on its rising edge.
REQ-004 px_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 vs_in  in  1  frame-valid, the same signal that drives the statistics block.
REQ-006 gray_sum_L_in, gray_sum_H_in  in  32 each  latched frame gray sum; only H[7:0] is significant.
REQ-007 exp_time_in  in  32  measured exposure length of the last frame.
REQ-008 ae_en  in  1  1 = auto-exposure; 0 = manual tracking.
REQ-009 target_mean, tolerance  in  12 each  desired mean and dead-band half-width.
REQ-010 pix_log2  in  5  log2 of pixels summed per frame (0..31).
REQ-011 step_shift  in  4  step = exp_cur >> step_shift.
REQ-012 exp_min, exp_max  in  32 each  clamp limits; exp_min <= exp_max is guaranteed.
REQ-013 skip_frames  in  4  frames ignored after each issued update.
REQ-014 exp_set  out  32  new exposure value.
REQ-015 exp_set_valid / exp_set_ready  out / in  1 each  valid/ready handshake to the sensor register writer.
REQ-016 ae_mean  out  12  last computed frame mean; ae_locked  out  1  mean within dead-band.

Function
REQ-017 Frame end = vs_in 1->0, detected with a registered copy of vs_in in cycle N; stats are sampled in cycle N+1 (the statistics block latches on that same edge).
REQ-018 FSM states: IDLE, WAIT_STATS, CALC, ADJUST, ISSUE.
  - IDLE -> WAIT_STATS on frame end.
  - WAIT_STATS -> CALC after 1 cycle.
  - CALC -> ADJUST after 1 cycle.
  - ADJUST -> ISSUE when an update is needed, else -> IDLE.
  - ISSUE -> IDLE on valid&&ready.
REQ-019 The block SHALL skip evaluation of a frame end that arrives while skip_cnt != 0: skip_cnt decrements by 1 and the FSM stays in IDLE.
REQ-020 CALC: sum = {H[7:0], L} (40 bit); mean = sum >> pix_log2, saturated to 4095; registered to ae_mean.
REQ-021 ADJUST: err = |target_mean - mean|; if err <= tolerance, ae_locked = 1 and no update is issued. Otherwise ae_locked = 0 and step = max(exp_cur >> step_shift, 1).
REQ-022 Update direction: if mean < target, exp_new = min(exp_cur + step, exp_max), computed with a 33-bit sum and no wrap. Otherwise exp_new = max(exp_cur - step, exp_min), with no underflow below 0.
REQ-023 An update whose exp_new equals exp_cur SHALL NOT enter ISSUE.
REQ-024 Entering ISSUE: exp_cur <= exp_new, exp_set <= exp_new, exp_set_valid = 1 and skip_cnt <= skip_frames. ISSUE is first reached at cycle N+4.
REQ-025 exp_set_valid SHALL stay high and exp_set stable until ready is sampled high; valid drops the cycle after the handshake.
REQ-026 A frame end arriving during WAIT_STATS, CALC, ADJUST or ISSUE is ignored and not queued; skip_cnt is unchanged.
REQ-027 ae_en = 0: the FSM runs CALC only (ae_mean is updated), issues nothing, and sets exp_cur <= exp_time_in at each frame end so that re-enabling is bumpless.
REQ-028 ae_en falling during ISSUE SHALL NOT abort the handshake.
REQ-029 Config inputs are sampled in the cycle each is used; changing them mid-frame has no other effect.

Reset
REQ-030 On px_reset_n low, asynchronously:
  - state = IDLE;
  - exp_cur = exp_set = EXP_INIT;
  - exp_set_valid = 0, ae_locked = 0, ae_mean = 0;
  - skip_cnt = 0;
  - vs_in register = 0.
REQ-031 Reset mid-ISSUE drops valid immediately. No transaction is retained, and the first frame end after release is evaluated normally.

Structure
REQ-032 Package sensor_ae_pkg SHALL hold the FSM state enum and the width constants (EXP_W=32, MEAN_W=12, SUM_W=40).
REQ-033 Step/clamp arithmetic (REQ-021/022) SHALL be a combinational sub-module sensor_ae_step; the FSM and registers live in sensor_ae_ctrl.

Verification
Common setup: pix_log2=10, target=2048, tol=64, step_shift=3, exp_cur=1000, exp_min=16, exp_max=4096, ready=1.
REQ-034 Sum 1,024,000 -> ae_mean=1000; exp_set=1125 with valid at N+4 for one cycle; ae_locked=0.
REQ-035 Sum 3,072,000 -> ae_mean=3000, exp_set=875. Sum 2,129,920 -> mean 2080, ae_locked=1, no valid.
REQ-036 exp_cur=4000, step_shift=3, mean=1000 -> exp_set=4096 (clamped). H=0x01 -> ae_mean=4095.
REQ-037 ready held low 5 cycles -> valid and exp_set stable throughout; a vs_in fall during that window produces no second update.
REQ-038 skip_frames=2 -> the two frame ends after the handshake produce no evaluation, and the third is evaluated; ae_en=0 with exp_time_in=777 then ae_en=1 -> the next step is based on exp_cur=777.
